nx_mesh_egress: RTL and testbench

Output collector at the south edge of the node mesh. It consumes the outbound message stream leaving a bottom-row node. It decodes signal-state messages into a host-visible output vector. Once per trigger cycle, after the expected number of updates has arrived, it presents a snapshot of that vector to the host over a valid/ready interface.

---
 rtl/nx_pkg.sv | 31 +++
 rtl/nx_egress_unpack.sv | 41 ++++
 rtl/nx_mesh_egress.sv | 129 ++++++++++++
 tb/tb_nx_mesh_egress.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_pkg.sv
// nx_pkg: mesh message field layout, command codes and egress FSM states.
// Shared by every egress-side block.
package nx_pkg;

  localparam int NX_STREAM_W = 32;
  localparam int NX_ROW_W    = 4;
  localparam int NX_COL_W    = 4;
  localparam int NX_CMD_W    = 2;
  localparam int NX_IDX_W    = 3;

  // Fields are packed from the MSB down: row, col, command, idx, state.
  localparam int NX_ROW_LSB   = NX_STREAM_W - NX_ROW_W;
  localparam int NX_COL_LSB   = NX_ROW_LSB - NX_COL_W;
  localparam int NX_CMD_LSB   = NX_COL_LSB - NX_CMD_W;
  localparam int NX_IDX_LSB   = NX_CMD_LSB - NX_IDX_W;
  localparam int NX_STATE_BIT = NX_IDX_LSB - 1;

  typedef enum logic [NX_CMD_W-1:0] {
    NX_CMD_NOP    = 2'd0,
    NX_CMD_CFG    = 2'd1,
    NX_CMD_SIGNAL = 2'd2,
    NX_CMD_RSVD   = 2'd3
  } nx_cmd_e;

  typedef enum logic [1:0] {
    EG_IDLE,
    EG_COLLECT,
    EG_EMIT
  } nx_eg_state_e;

endpackage

// File: rtl/nx_egress_unpack.sv
// nx_egress_unpack: splits an inbound mesh message into its fields
// and classifies it as a usable signal update.
module nx_egress_unpack
  import nx_pkg::*;
#(
  parameter int STREAM_WIDTH   = NX_STREAM_W,
  parameter int ADDR_ROW_WIDTH = NX_ROW_W,
  parameter int ADDR_COL_WIDTH = NX_COL_W,
  parameter int COMMAND_WIDTH  = NX_CMD_W,
  parameter int IDX_WIDTH      = NX_IDX_W,
  parameter int COLUMNS        = 4,
  parameter int ROW_LSB        = NX_ROW_LSB,
  parameter int COL_LSB        = NX_COL_LSB,
  parameter int CMD_LSB        = NX_CMD_LSB,
  parameter int IDX_LSB        = NX_IDX_LSB,
  parameter int STATE_BIT      = NX_STATE_BIT
) (
  input  logic [STREAM_WIDTH-1:0]   data,
  output logic [ADDR_COL_WIDTH-1:0] col,
  output logic [IDX_WIDTH-1:0]      idx,
  output logic                      state,
  output logic                      is_signal,
  output logic                      in_range
);

  logic [COMMAND_WIDTH-1:0] cmd;
  logic                     unused_bits;

  assign col   = data[COL_LSB +: ADDR_COL_WIDTH];
  assign idx   = data[IDX_LSB +: IDX_WIDTH];
  assign state = data[STATE_BIT];
  assign cmd   = data[CMD_LSB +: COMMAND_WIDTH];

  assign is_signal = (cmd == NX_CMD_SIGNAL);
  assign in_range  = (32'(col) < COLUMNS);

  // Row and the low payload bits carry nothing for the egress edge.
  assign unused_bits = ^{data[ROW_LSB +: ADDR_ROW_WIDTH],
                         data[STATE_BIT-1:0]};

endmodule

// File: rtl/nx_mesh_egress.sv
// nx_mesh_egress: collects signal messages into an output vector and
// emits one snapshot per trigger. NX_EGRESS_CHANGE_MASK_EN adds out_changed_o.
module nx_mesh_egress
  import nx_pkg::*;
#(
  parameter int STREAM_WIDTH   = NX_STREAM_W,
  parameter int ADDR_ROW_WIDTH = NX_ROW_W,
  parameter int ADDR_COL_WIDTH = NX_COL_W,
  parameter int COMMAND_WIDTH  = NX_CMD_W,
  parameter int OUTPUTS        = 8,
  parameter int COLUMNS        = 4,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         trigger_i,
  input  logic [COUNT_WIDTH-1:0]       expected_i,
  input  logic [STREAM_WIDTH-1:0]      ib_data_i,
  input  logic                         ib_valid_i,
  output logic                         ib_ready_o,
  output logic [COLUMNS*OUTPUTS-1:0]   out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [COUNT_WIDTH-1:0]       dropped_o,
`ifdef NX_EGRESS_CHANGE_MASK_EN
  output logic [COLUMNS*OUTPUTS-1:0]   out_changed_o,
`endif
  output logic                         overrun_o
);

  localparam int IDX_WIDTH = $clog2(OUTPUTS);
  localparam int VEC_WIDTH = COLUMNS * OUTPUTS;
  localparam int SEL_WIDTH = $clog2(VEC_WIDTH);

  nx_eg_state_e state_q, state_d;

  logic [COUNT_WIDTH-1:0]    exp_q, rcvd_q, rcvd_inc;
  logic [VEC_WIDTH-1:0]      vec_q;
  logic [ADDR_COL_WIDTH-1:0] col;
  logic [IDX_WIDTH-1:0]      idx;
  logic [SEL_WIDTH-1:0]      bit_sel;
  logic bit_state, is_signal, in_range;
  logic accept, update, drop, done;

  nx_egress_unpack #(
    .STREAM_WIDTH   (STREAM_WIDTH),
    .ADDR_ROW_WIDTH (ADDR_ROW_WIDTH),
    .ADDR_COL_WIDTH (ADDR_COL_WIDTH),
    .COMMAND_WIDTH  (COMMAND_WIDTH),
    .IDX_WIDTH      (IDX_WIDTH),
    .COLUMNS        (COLUMNS)
  ) u_unpack (
    .data      (ib_data_i),
    .col       (col),
    .idx       (idx),
    .state     (bit_state),
    .is_signal (is_signal),
    .in_range  (in_range)
  );

  assign accept   = ib_valid_i & ib_ready_o;
  assign update   = accept & is_signal & in_range;
  assign drop     = accept & ~(is_signal & in_range);
  assign rcvd_inc = rcvd_q + COUNT_WIDTH'(1);
  assign bit_sel  = SEL_WIDTH'(col) * SEL_WIDTH'(OUTPUTS)
                  + SEL_WIDTH'(idx);

  // The equality term alone covers a zero expectation on entry.
  assign done = (rcvd_q == exp_q) | (update & (rcvd_inc == exp_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EG_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EG_IDLE:    if (trigger_i)   state_d = EG_COLLECT;
      EG_COLLECT: if (done)        state_d = EG_EMIT;
      EG_EMIT:    if (out_ready_i) state_d = EG_IDLE;
      default:                     state_d = EG_IDLE;
    endcase
  end

  always_comb begin
    ib_ready_o  = (state_q == EG_COLLECT);
    out_valid_o = (state_q == EG_EMIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_q     <= '0;
      rcvd_q    <= '0;
      vec_q     <= '0;
      dropped_o <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (state_q == EG_IDLE && trigger_i) begin
        exp_q  <= expected_i;
        rcvd_q <= '0;
      end
      if (update) begin
        vec_q[bit_sel] <= bit_state;
        rcvd_q         <= rcvd_inc;
      end
      if (drop && dropped_o != '1)
        dropped_o <= dropped_o + COUNT_WIDTH'(1);
      if (trigger_i && state_q != EG_IDLE)
        overrun_o <= 1'b1;
    end
  end

  assign out_data_o = vec_q;

`ifdef NX_EGRESS_CHANGE_MASK_EN
  logic [VEC_WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      prev_q <= '0;
    else if (out_valid_o && out_ready_i)
      prev_q <= vec_q;
  end

  assign out_changed_o = vec_q ^ prev_q;
`endif

endmodule

// File: tb/tb_nx_mesh_egress.sv
// tb_nx_mesh_egress: randomized + directed scoreboard bench for nx_mesh_egress.
// Snapshots are predicted from the message rules and checked by a monitor.
module tb_nx_mesh_egress;

  logic        clk = 1'b0;
  logic        rst, trigger;
  logic [7:0]  expected;
  logic [31:0] ib_data;
  logic        ib_valid, ib_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic [7:0]  dropped;
  logic        overrun;
`ifdef NX_EGRESS_CHANGE_MASK_EN
  logic [31:0] out_changed;
`endif

  always #5 clk = ~clk;

  nx_mesh_egress dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .trigger_i     (trigger),
    .expected_i    (expected),
    .ib_data_i     (ib_data),
    .ib_valid_i    (ib_valid),
    .ib_ready_o    (ib_ready),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .dropped_o     (dropped),
`ifdef NX_EGRESS_CHANGE_MASK_EN
    .out_changed_o (out_changed),
`endif
    .overrun_o     (overrun)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_vec  = '0;
  logic [31:0] m_prev = '0;
  int          m_dropped = 0;
  logic [31:0] snap_q[$];
  logic [31:0] chg_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] row,
    input logic [3:0] col, input logic [1:0] cmd,
    input logic [2:0] idx, input logic st);
    logic [17:0] junk;
    junk = 18'($urandom);
    return {row, col, cmd, idx, st, junk};
  endfunction

  function automatic logic [31:0] rnd_valid();
    return mk(4'($urandom), 4'($urandom_range(0, 3)), 2'd2,
              3'($urandom), 1'($urandom));
  endfunction

  function automatic logic [31:0] rnd_drop();
    logic [1:0] c;
    if ($urandom_range(0, 1) == 0) begin
      c = 2'($urandom_range(0, 2));
      if (c == 2'd2) c = 2'd3;
      return mk(4'($urandom), 4'($urandom), c, 3'($urandom), 1'($urandom));
    end
    return mk(4'($urandom), 4'($urandom_range(4, 15)), 2'd2,
              3'($urandom), 1'($urandom));
  endfunction

  // Reference rule: a signal to an existing column writes one bit,
  // anything else bumps a saturating drop count.
  task automatic model_apply(input logic [31:0] m);
    int col, idx;
    col = int'(m[27:24]);
    idx = int'(m[21:19]);
    if (m[23:22] == 2'd2 && col < 4) m_vec[col * 8 + idx] = m[18];
    else if (m_dropped < 255) m_dropped++;
  endtask

  task automatic send(input logic [31:0] m);
    int n = 0;
    ib_data  = m;
    ib_valid = 1'b1;
    @(negedge clk);
    while (!ib_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ib_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: ib_ready_o=0, want 1");
      ib_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ib_valid = 1'b0;
    model_apply(m);
  endtask

  task automatic pulse_trigger(input logic [7:0] n);
    trigger  = 1'b1;
    expected = n;
    @(posedge clk); #1;
    trigger  = 1'b0;
    expected = 8'($urandom);
  endtask

  task automatic expect_emit(input string tag);
    snap_q.push_back(m_vec);
    chg_q.push_back(m_vec ^ m_prev);
    m_prev = m_vec;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_ib_ready"}, ib_ready, 0);
    check({tag, "_dropped"}, dropped, 64'(m_dropped));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("emit_release", out_valid, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ib_ready"}, ib_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic run_cycle(input int n, input int nd, input bit hold);
    logic [31:0] msgs[$];
    for (int i = 0; i < n - 1; i++)
      msgs.insert($urandom_range(0, msgs.size()), rnd_valid());
    for (int i = 0; i < nd; i++)
      msgs.insert($urandom_range(0, msgs.size()), rnd_drop());
    msgs.push_back(rnd_valid());
    out_ready = !hold;
    pulse_trigger(8'(n));
    check("collect_ready", ib_ready, 1);
    foreach (msgs[i]) send(msgs[i]);
    expect_emit("rand");
    if (hold) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    wait_idle();
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] want;
    logic [31:0] want_chg;
    if (!rst && out_valid && out_ready) begin
      if (snap_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_snapshot: got %0h, want none", out_data);
      end else begin
        want     = snap_q.pop_front();
        want_chg = chg_q.pop_front();
        check("snapshot", out_data, want);
`ifdef NX_EGRESS_CHANGE_MASK_EN
        check("change_mask", out_changed, want_chg);
`else
        if (want_chg === 32'hx) $display("unreachable");
`endif
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; trigger = 1'b0; expected = '0;
    ib_data = '0; ib_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("por");

    // Three signals; completion is visible the cycle after the last accept.
    pulse_trigger(8'd3);
    send(mk(4'd3, 4'd0, 2'd2, 3'd1, 1'b1));
    send(mk(4'd3, 4'd2, 2'd2, 3'd7, 1'b1));
    check("tp1_not_early", out_valid, 0);
    send(mk(4'd3, 4'd3, 2'd2, 3'd0, 1'b1));
    check("tp1_data", out_data, 32'h0180_0002);
    expect_emit("tp1");
    wait_idle();

    // Wrong command and out-of-range column are discarded.
    pulse_trigger(8'd2);
    send(mk(4'd1, 4'd1, 2'd1, 3'd2, 1'b1));
    send(mk(4'd1, 4'd5, 2'd2, 3'd2, 1'b1));
    send(mk(4'd1, 4'd1, 2'd2, 3'd4, 1'b1));
    check("tp2_not_early", out_valid, 0);
    send(mk(4'd1, 4'd0, 2'd2, 3'd1, 1'b0));
    check("tp2_dropped", dropped, 8'd2);
    expect_emit("tp2");
    wait_idle();

    // Host stalls the snapshot while inbound traffic is pending.
    out_ready = 1'b0;
    pulse_trigger(8'd1);
    send(rnd_valid());
    expect_emit("stall");
    ib_data  = rnd_valid();
    ib_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", out_data, m_vec);
      check("stall_valid", out_valid, 1);
      check("stall_ib_ready", ib_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", out_valid, 0);
    check("stall_ib_ready_idle", ib_ready, 0);
    ib_valid = 1'b0;
    check("stall_dropped", dropped, 64'(m_dropped));

    // Zero expectation emits the unchanged vector two cycles on.
    pulse_trigger(8'd0);
    check("exp0_not_early", out_valid, 0);
    @(posedge clk); #1;
    expect_emit("exp0");
    wait_idle();

    // A trigger mid-collection is flagged but does not restart it.
    pulse_trigger(8'd2);
    send(rnd_valid());
    check("overrun_clear", overrun, 0);
    pulse_trigger(8'd7);
    check("overrun_set", overrun, 1);
    send(rnd_valid());
    expect_emit("overrun_cycle");
    wait_idle();
    check("overrun_sticky", overrun, 1);

    for (int c = 0; c < 25; c++)
      run_cycle($urandom_range(1, 6), $urandom_range(0, 3),
                $urandom_range(0, 3) == 0);

    run_cycle(1, 260, 1'b0);
    check("drop_saturated", dropped, 8'hff);
    check("overrun_still", overrun, 1);

    // Reset in the middle of a collection.
    pulse_trigger(8'd3);
    send(rnd_valid());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_vec = '0; m_prev = '0; m_dropped = 0;
    check_reset("midrst");

`ifdef NX_EGRESS_CHANGE_MASK_EN
    pulse_trigger(8'd1);
    send(mk(4'd0, 4'd0, 2'd2, 3'd5, 1'b1));
    check("chg_first", out_changed, 32'h20);
    expect_emit("chg1");
    wait_idle();
    pulse_trigger(8'd2);
    send(mk(4'd0, 4'd0, 2'd2, 3'd5, 1'b0));
    send(mk(4'd0, 4'd1, 2'd2, 3'd1, 1'b1));
    check("chg_second", out_changed, 32'h220);
    expect_emit("chg2");
    wait_idle();
`endif

    // Trigger coinciding with the snapshot handshake is an overrun.
    out_ready = 1'b0;
    pulse_trigger(8'd1);
    send(rnd_valid());
    expect_emit("hs");
    @(posedge clk); #1;
    out_ready = 1'b1;
    trigger   = 1'b1;
    expected  = 8'd1;
    @(posedge clk); #1;
    trigger = 1'b0;
    check("hs_idle", out_valid, 0);
    check("hs_overrun", overrun, 1);
    check("hs_ignored", ib_ready, 0);
    pulse_trigger(8'd0);
    check("retrigger_accepted", ib_ready, 1);
    @(posedge clk); #1;
    expect_emit("retrig");
    wait_idle();

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", snap_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
